// File: rtl/gate_pkg.sv
// Shared definitions for the multi-input gate: reduction mode encoding and popcount width.
package gate_pkg;

  localparam int unsigned POP_W = 6;

  typedef enum logic [2:0] {
    MODE_AND    = 3'd0,
    MODE_OR     = 3'd1,
    MODE_XOR    = 3'd2,
    MODE_NAND   = 3'd3,
    MODE_NOR    = 3'd4,
    MODE_XNOR   = 3'd5,
    MODE_MAJ    = 3'd6,
    MODE_ONEHOT = 3'd7
  } gate_mode_e;

endpackage

// File: rtl/popcount_n.sv
// Combinational count of set bits in an N-bit word.
module popcount_n
  import gate_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     data,
  output logic [POP_W-1:0] pop
);

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + POP_W'(data[i]);
    end
  end

endmodule

// File: rtl/multi_input_gate_reg.sv
// Registered selectable reduction over N_IN inputs, with rising-edge pulse,
// saturating hit counter and registered popcount.
module multi_input_gate_reg
  import gate_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  input  logic [2:0]       mode,
  input  logic             clr,
  output logic             out_valid,
  output logic             out_data,
  output logic             rise,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [POP_W-1:0] pop
);

  logic [POP_W-1:0] pop_cnt;
  logic             res;
  logic             prev_res;
  gate_mode_e       mode_sel;

  popcount_n #(.N(N_IN)) u_popcount (
    .data (in_data),
    .pop  (pop_cnt)
  );

  assign mode_sel = gate_mode_e'(mode);

  always_comb begin
    res = 1'b0;
    case (mode_sel)
      MODE_AND:    res = &in_data;
      MODE_OR:     res = |in_data;
      MODE_XOR:    res = ^in_data;
      MODE_NAND:   res = ~&in_data;
      MODE_NOR:    res = ~|in_data;
      MODE_XNOR:   res = ~^in_data;
      MODE_MAJ:    res = (pop_cnt > POP_W'(N_IN / 2));
      MODE_ONEHOT: res = (pop_cnt == POP_W'(1));
      default:     res = 1'b0;
    endcase
  end

  // clr overrides the counter and edge history even on a valid cycle; rise
  // still uses the pre-clear history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      rise      <= 1'b0;
      hit_cnt   <= '0;
      pop       <= '0;
      prev_res  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= res;
        pop      <= pop_cnt;
        rise     <= res & ~prev_res;
      end else begin
        rise     <= 1'b0;
      end
      if (clr) begin
        hit_cnt  <= '0;
        prev_res <= 1'b0;
      end else if (in_valid) begin
        prev_res <= res;
        if (res && (hit_cnt != '1)) begin
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_input_gate_reg.sv
// Scoreboard bench: three instances (N_IN=4/CNT_W=8, N_IN=4/CNT_W=3, N_IN=7/CNT_W=8).
module tb_multi_input_gate_reg;
  import gate_pkg::*;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        v, cl, ov, od, ri;
  logic [2:0][2:0]   md;
  logic [2:0][31:0]  dd;
  logic [7:0]        hc_a, hc_c;
  logic [2:0]        hc_b;
  logic [5:0]        pa, pb, pc;

  multi_input_gate_reg #(.N_IN(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_data(dd[0][3:0]), .mode(md[0]),
    .clr(cl[0]), .out_valid(ov[0]), .out_data(od[0]), .rise(ri[0]), .hit_cnt(hc_a), .pop(pa));
  multi_input_gate_reg #(.N_IN(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_data(dd[1][3:0]), .mode(md[1]),
    .clr(cl[1]), .out_valid(ov[1]), .out_data(od[1]), .rise(ri[1]), .hit_cnt(hc_b), .pop(pb));
  multi_input_gate_reg #(.N_IN(7), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_data(dd[2][6:0]), .mode(md[2]),
    .clr(cl[2]), .out_valid(ov[2]), .out_data(od[2]), .rise(ri[2]), .hit_cnt(hc_c), .pop(pc));

  typedef struct {
    int   id;
    logic valid;
    logic data;
    logic rise;
    int   cnt;
    int   pop;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   nin  [3] = '{4, 4, 7};
  int   cmax [3] = '{255, 7, 255};
  logic m_prev [3];
  logic m_out  [3];
  int   m_cnt  [3];
  int   m_pop  [3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [31:0] d, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(d[i]);
    return c;
  endfunction

  function automatic logic model_res(input logic [2:0] m, input logic [31:0] d, input int n);
    int c;
    c = popc(d, n);
    case (m)
      3'd0: return c == n;
      3'd1: return c != 0;
      3'd2: return (c % 2) == 1;
      3'd3: return c != n;
      3'd4: return c == 0;
      3'd5: return (c % 2) == 0;
      3'd6: return c > (n / 2);
      default: return c == 1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = 1'b0; m_out[i] = 1'b0; m_cnt[i] = 0; m_pop[i] = 0;
    end
    sb.delete();
  endtask

  function automatic logic [31:0] act_cnt(input int id);
    if (id == 0) return 32'(hc_a);
    if (id == 1) return 32'(hc_b);
    return 32'(hc_c);
  endfunction

  function automatic logic [31:0] act_pop(input int id);
    if (id == 0) return 32'(pa);
    if (id == 1) return 32'(pb);
    return 32'(pc);
  endfunction

  // Drive one cycle on instance id (others idle), push the expected outputs,
  // then pop and compare one step after the sampling edge.
  task automatic drive(input int id, input logic vin, input logic [31:0] data,
                       input logic [2:0] m, input logic c);
    exp_t e;
    logic r;
    @(negedge clk);
    v = '0; cl = '0;
    v[id] = vin; cl[id] = c; dd[id] = data; md[id] = m;
    e.id = id;
    if (vin) begin
      r = model_res(m, data, nin[id]);
      e.valid = 1'b1;
      e.rise = r & ~m_prev[id];
      m_out[id] = r;
      m_pop[id] = popc(data, nin[id]);
      m_prev[id] = r;
      if (r && m_cnt[id] < cmax[id]) m_cnt[id]++;
    end else begin
      e.valid = 1'b0;
      e.rise = 1'b0;
    end
    if (c) begin
      m_cnt[id] = 0;
      m_prev[id] = 1'b0;
    end
    e.data = m_out[id];
    e.cnt = m_cnt[id];
    e.pop = m_pop[id];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq($sformatf("out_valid[%0d]", e.id), 32'(ov[e.id]), 32'(e.valid));
    check_eq($sformatf("out_data[%0d]", e.id), 32'(od[e.id]), 32'(e.data));
    check_eq($sformatf("rise[%0d]", e.id), 32'(ri[e.id]), 32'(e.rise));
    check_eq($sformatf("hit_cnt[%0d]", e.id), act_cnt(e.id), 32'(e.cnt));
    check_eq($sformatf("pop[%0d]", e.id), act_pop(e.id), 32'(e.pop));
  endtask

  logic [7:0] mode_tab;

  initial begin
    v = '0; cl = '0; dd = '0; md = '0;
    model_reset();
    #1;
    check_eq("reset_valid", 32'(ov[0]), 0);
    check_eq("reset_data", 32'(od[0]), 0);
    check_eq("reset_cnt", 32'(hc_a), 0);
    check_eq("reset_pop", 32'(pa), 0);
    #1 rst_n = 1'b1;

    // Asynchronous reset while a sample is in flight
    @(negedge clk);
    v[0] = 1'b1; dd[0] = 32'hF; md[0] = 3'(MODE_OR);
    @(posedge clk); #1;
    check_eq("pre_rst_valid", 32'(ov[0]), 1);
    check_eq("pre_rst_cnt", 32'(hc_a), 1);
    #4 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(ov[0]), 0);
    check_eq("async_rst_data", 32'(od[0]), 0);
    check_eq("async_rst_rise", 32'(ri[0]), 0);
    check_eq("async_rst_cnt", 32'(hc_a), 0);
    check_eq("async_rst_pop", 32'(pa), 0);
    v = '0;
    model_reset();
    #6 rst_n = 1'b1;

    // Exhaustive OR sweep, then an idle cycle
    for (int i = 0; i < 16; i++) drive(0, 1'b1, 32'(i), 3'(MODE_OR), 1'b0);
    drive(0, 1'b0, 32'h0, 3'(MODE_OR), 1'b0);
    check_eq("or_sweep_hits", 32'(hc_a), 15);

    // Every mode on 0111
    mode_tab = 8'b0100_1110;
    for (int m = 0; m < 8; m++) begin
      drive(0, 1'b1, 32'b0111, 3'(m), 1'b0);
      check_eq($sformatf("mode%0d_0111", m), 32'(od[0]), 32'(mode_tab[m]));
      check_eq($sformatf("mode%0d_pop", m), 32'(pa), 3);
    end

    // Rise sequence with an idle gap before the 5th sample
    drive(0, 1'b0, 32'h0, 3'(MODE_OR), 1'b1);
    drive(0, 1'b1, 32'b0000, 3'(MODE_OR), 1'b0);
    drive(0, 1'b1, 32'b0001, 3'(MODE_OR), 1'b0);
    check_eq("rise_2nd", 32'(ri[0]), 1);
    drive(0, 1'b1, 32'b0001, 3'(MODE_OR), 1'b0);
    drive(0, 1'b1, 32'b0000, 3'(MODE_OR), 1'b0);
    drive(0, 1'b0, 32'b0000, 3'(MODE_OR), 1'b0);
    drive(0, 1'b1, 32'b1000, 3'(MODE_OR), 1'b0);
    check_eq("rise_5th", 32'(ri[0]), 1);

    // Saturation and clear on the 3-bit counter
    for (int i = 0; i < 10; i++) drive(1, 1'b1, 32'b0001, 3'(MODE_OR), 1'b0);
    check_eq("sat_hold", 32'(hc_b), 7);
    drive(1, 1'b1, 32'b0010, 3'(MODE_OR), 1'b1);
    check_eq("clr_wins", 32'(hc_b), 0);
    drive(1, 1'b1, 32'b0100, 3'(MODE_OR), 1'b0);
    check_eq("after_clr", 32'(hc_b), 1);

    // N_IN=7 majority / one-hot boundaries
    drive(2, 1'b1, 32'b0001111, 3'(MODE_MAJ), 1'b0);
    check_eq("maj7_4", 32'(od[2]), 1);
    drive(2, 1'b1, 32'b0000111, 3'(MODE_MAJ), 1'b0);
    check_eq("maj7_3", 32'(od[2]), 0);
    drive(2, 1'b1, 32'b1000000, 3'(MODE_ONEHOT), 1'b0);
    check_eq("onehot7", 32'(od[2]), 1);
    drive(2, 1'b1, 32'b1111111, 3'(MODE_AND), 1'b0);
    check_eq("pop7_all", 32'(pc), 7);

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      drive(i % 3, ($urandom_range(0, 3) != 0), $urandom(), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
